// File: rtl/adder_stim_gen_if.sv
// Operand/result bus between the stimulus generator and the adder under test.
//   a, b  : operands, driven by the generator
//   valid : a/b are meaningful this cycle
//   c     : adder result, driven by the adder
// master = generator side, slave = adder side.
interface adder_stim_gen_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned RES_W  = 7
);
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              valid;
  logic [RES_W-1:0]  c;

  modport master (output a, b, valid, input c);
  modport slave  (input a, b, valid, output c);
endinterface

// File: rtl/adder_stim_gen.sv
// LFSR-driven stimulus generator and checker for a pipelined adder.
// Each transaction drives one valid beat of pseudo-random operands, waits
// LATENCY cycles and compares the returned sum, accumulating pass/fail counts.
//   clk, reset        : clock (rising edge), asynchronous active-low reset
//   start             : begin a run (accepted only when idle or done)
//   num_txn, seed     : run length and LFSR seed, captured with start
//   bus               : operand/result bus (master side)
//   busy, done        : run in progress / run complete (held until next start)
//   pass_cnt, fail_cnt: saturating compare counts for the current run
module adder_stim_gen #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned RES_W   = 7,
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          num_txn,
  input  logic [15:0]          seed,
  adder_stim_gen_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          pass_cnt,
  output logic [15:0]          fail_cnt
);

  localparam int unsigned WAIT_W = 3;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRIVE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       txn_q, txn_d;
  logic [15:0]       num_txn_q, num_txn_d;
  logic [15:0]       pass_q, pass_d;
  logic [15:0]       fail_q, fail_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [RES_W-1:0]  exp_q, exp_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // One step of the right-shifting Galois LFSR
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Next-state and next-output logic; outputs are derived from the next state
  // so that every output comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    txn_d     = txn_q;
    num_txn_d = num_txn_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    wait_d    = wait_q;
    exp_d     = exp_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lfsr_d    = (seed == 16'h0000) ? LFSR_INIT : seed;
          txn_d     = 16'h0000;
          num_txn_d = num_txn;
          pass_d    = 16'h0000;
          fail_d    = 16'h0000;
          state_d   = (num_txn == 16'h0000) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (LATENCY == 1) begin
          state_d = ST_CHECK;
        end else begin
          wait_d  = WAIT_W'(LATENCY - 2);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      ST_CHECK: begin
        if (bus.c == exp_q) begin
          pass_d = (pass_q == 16'hFFFF) ? pass_q : pass_q + 16'd1;
        end else begin
          fail_d = (fail_q == 16'hFFFF) ? fail_q : fail_q + 16'd1;
        end
        lfsr_d  = lfsr_step(lfsr_q);
        txn_d   = txn_q + 16'd1;
        state_d = (txn_d == num_txn_q) ? ST_DONE : ST_DRIVE;
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_DRIVE);
    a_d     = valid_d ? lfsr_d[DATA_W-1:0]        : '0;
    b_d     = valid_d ? lfsr_d[2*DATA_W-1:DATA_W] : '0;
    if (valid_d) begin
      exp_d = RES_W'(a_d) + RES_W'(b_d);
    end
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_INIT;
      txn_q     <= 16'h0000;
      num_txn_q <= 16'h0000;
      pass_q    <= 16'h0000;
      fail_q    <= 16'h0000;
      wait_q    <= '0;
      exp_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      txn_q     <= txn_d;
      num_txn_q <= num_txn_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      wait_q    <= wait_d;
      exp_q     <= exp_d;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_adder_stim_gen.sv
// Bench for adder_stim_gen: two instances (LATENCY 1 with a registered adder
// that can be forced to output 0, LATENCY 3 with a 3-stage adder). Expected
// operand pairs come from an independent LFSR model pushed into per-instance
// queues at start and popped whenever the DUT raises valid.
module tb_adder_stim_gen;

  localparam int unsigned DW = 4;
  localparam int unsigned RW = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start2;
  logic [15:0] num1, num2, seed1, seed2;
  logic        busy1, busy2, done1, done2;
  logic [15:0] pass1, pass2, fail1, fail2;
  logic        stuck;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int vcnt1 = 0, vcnt2 = 0;
  int last1 = 0, last2 = 0;
  bit prev1 = 0, prev2 = 0;

  adder_stim_gen_if #(.DATA_W(DW), .RES_W(RW)) if1();
  adder_stim_gen_if #(.DATA_W(DW), .RES_W(RW)) if2();

  adder_stim_gen #(.DATA_W(DW), .RES_W(RW), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .num_txn(num1), .seed(seed1),
    .bus(if1), .busy(busy1), .done(done1), .pass_cnt(pass1), .fail_cnt(fail1)
  );

  adder_stim_gen #(.DATA_W(DW), .RES_W(RW), .LATENCY(3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .num_txn(num2), .seed(seed2),
    .bus(if2), .busy(busy2), .done(done2), .pass_cnt(pass2), .fail_cnt(fail2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Registered adder (optionally stuck at zero) and 3-stage adder
  always @(posedge clk) if1.c <= stuck ? '0 : RW'(if1.a) + RW'(if1.b);

  logic [RW-1:0] p1, p2;
  always @(posedge clk) begin
    p1    <= RW'(if2.a) + RW'(if2.b);
    p2    <= p1;
    if2.c <= p2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic fb;
    fb = s[0];
    s  = {1'b0, s[15:1]};
    if (fb) s = s ^ 16'hB400;
    return s;
  endfunction

  // Push the expected {a,b} sequence of a run; nz = number of nonzero sums
  task automatic push_run(input int sel, input logic [15:0] sd, input int n, output int nz);
    logic [15:0] l;
    logic [3:0]  ea, eb;
    l  = (sd == 16'h0000) ? 16'hACE1 : sd;
    nz = 0;
    for (int i = 0; i < n; i++) begin
      ea = l[3:0];
      eb = l[7:4];
      if (sel == 1) q1.push_back({ea, eb});
      else          q2.push_back({ea, eb});
      if ((5'(ea) + 5'(eb)) != 5'd0) nz++;
      l = m_step(l);
    end
  endtask

  // Pulse start for one cycle from a negedge; returns at the negedge after it is sampled
  task automatic start_run(input int sel, input logic [15:0] sd, input logic [15:0] n);
    if (sel == 1) begin num1 = n; seed1 = sd; start1 = 1'b1; end
    else          begin num2 = n; seed2 = sd; start2 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int limit, output int n);
    n = 0;
    while (((sel == 1) ? done1 : done2) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (((sel == 1) ? done1 : done2) !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  // Monitors: pop expected operands on valid, check spacing inside a run
  always @(negedge clk) begin
    if (if1.valid === 1'b1) begin
      vcnt1++;
      if (q1.size() == 0) chk("spurious_valid1", 1, 0);
      else                chk("ab1", {if1.a, if1.b}, q1.pop_front());
      if (prev1) chk("period1", cyc - last1, 2);
      prev1 = 1;
      last1 = cyc;
    end else begin
      chk("ab_idle1", {if1.a, if1.b}, 0);
      if (busy1 !== 1'b1) prev1 = 0;
    end
  end

  always @(negedge clk) begin
    if (if2.valid === 1'b1) begin
      vcnt2++;
      if (q2.size() == 0) chk("spurious_valid2", 1, 0);
      else                chk("ab2", {if2.a, if2.b}, q2.pop_front());
      if (prev2) chk("period2", cyc - last2, 4);
      prev2 = 1;
      last2 = cyc;
    end else begin
      chk("ab_idle2", {if2.a, if2.b}, 0);
      if (busy2 !== 1'b1) prev2 = 0;
    end
  end

  initial begin
    int nz, n, v0;
    reset  = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    num1   = '0;   num2   = '0;
    seed1  = '0;   seed2  = '0;
    stuck  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_valid1", if1.valid, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_pass1", pass1, 0);
    chk("rst_fail1", fail1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_done2", done2, 0);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);

    // num_txn = 0: straight to DONE, no valid
    v0 = vcnt1;
    start_run(1, 16'h0042, 16'd0);
    chk("nt0_done", done1, 1);
    chk("nt0_busy", busy1, 0);
    chk("nt0_pass", pass1, 0);
    chk("nt0_fail", fail1, 0);
    @(negedge clk);
    chk("nt0_novalid", vcnt1 - v0, 0);

    // seed 0, one transaction
    push_run(1, 16'h0000, 1, nz);
    start_run(1, 16'h0000, 16'd1);
    chk("s0_valid", if1.valid, 1);
    chk("s0_ab", {if1.a, if1.b}, 8'h1E);
    chk("s0_busy", busy1, 1);
    chk("s0_done_clr", done1, 0);
    @(negedge clk);
    chk("s0_valid_low", if1.valid, 0);
    chk("s0_c", if1.c, 7'h0F);
    chk("s0_done_early", done1, 0);
    @(negedge clk);
    chk("s0_done", done1, 1);
    chk("s0_busy_end", busy1, 0);
    chk("s0_pass", pass1, 1);
    chk("s0_fail", fail1, 0);
    repeat (3) @(negedge clk);
    chk("s0_done_held", done1, 1);

    // 100 transactions, correct adder
    v0 = vcnt1;
    push_run(1, 16'h1234, 100, nz);
    start_run(1, 16'h1234, 16'd100);
    wait_done(1, 1000, n);
    chk("r100_len", n, 200);
    chk("r100_pass", pass1, 100);
    chk("r100_fail", fail1, 0);
    chk("r100_valids", vcnt1 - v0, 100);
    chk("r100_q_empty", q1.size(), 0);

    // same run, result stuck at zero
    stuck = 1'b1;
    push_run(1, 16'h1234, 100, nz);
    start_run(1, 16'h1234, 16'd100);
    wait_done(1, 1000, n);
    chk("stuck_fail", fail1, nz);
    chk("stuck_pass", pass1, 100 - nz);
    chk("stuck_total", 32'(pass1) + 32'(fail1), 100);
    stuck = 1'b0;
    @(negedge clk);

    // reset in the middle of a run
    push_run(1, 16'h5A5A, 10, nz);
    start_run(1, 16'h5A5A, 16'd10);
    repeat (6) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_valid", if1.valid, 0);
    chk("mid_rst_ab", {if1.a, if1.b}, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_done", done1, 0);
    chk("mid_rst_pass", pass1, 0);
    chk("mid_rst_fail", fail1, 0);
    q1.delete();
    @(negedge clk);
    #1 reset = 1'b1;
    v0 = vcnt1;
    repeat (10) @(negedge clk);
    chk("post_rst_novalid", vcnt1 - v0, 0);
    chk("post_rst_busy", busy1, 0);
    chk("post_rst_done", done1, 0);

    // LATENCY 3 with start re-asserted mid-run
    v0 = vcnt2;
    push_run(2, 16'hBEEF, 5, nz);
    start_run(2, 16'hBEEF, 16'd5);
    repeat (7) @(negedge clk);
    seed2  = 16'h1111;
    num2   = 16'd2;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("l3_busy_mid", busy2, 1);
    wait_done(2, 200, n);
    chk("l3_len", 8 + n, 20);
    chk("l3_pass", pass2, 5);
    chk("l3_fail", fail2, 0);
    chk("l3_valids", vcnt2 - v0, 5);
    chk("l3_q_empty", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
